// File: rtl/demux_rr_dispatcher.sv
// Round-robin burst dispatcher for a 1-to-N demux datapath.
// One-entry registered output stage; unselected lanes read as zero.
module demux_rr_dispatcher #(
  parameter  int N_OUT = 4,
  parameter  int DW    = 8,
  parameter  int BURST = 4,
  localparam int SW    = $clog2(N_OUT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_OUT-1:0]    en_mask,
  output logic [N_OUT*DW-1:0] out_data,
  output logic [N_OUT-1:0]    out_valid,
  input  logic [N_OUT-1:0]    out_ready,
  output logic [SW-1:0]       sel,
  output logic                busy
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e        state_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] hold_sel_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] data_q;
  logic          hv_q;

  // incl=1 may return s itself; incl=0 looks strictly after s,
  // wrapping back to s only when it is the sole enabled lane.
  function automatic logic [SW-1:0] scan(
    input logic [SW-1:0]    s,
    input logic [N_OUT-1:0] m,
    input logic             incl
  );
    logic [SW-1:0] r;
    logic [SW-1:0] lidx;
    int            off;
    r = s;
    for (int k = N_OUT - 1; k >= 0; k--) begin
      off  = incl ? k : k + 1;
      lidx = SW'((int'(s) + off) % N_OUT);
      if (m[lidx]) r = lidx;
    end
    return r;
  endfunction

  logic [SW-1:0] first_en;
  logic [SW-1:0] next_en;
  logic          any_en;
  logic          drain;
  logic          acc;
  logic          last;

  assign first_en = scan(ptr_q, en_mask, 1'b1);
  assign next_en  = scan(ptr_q, en_mask, 1'b0);
  assign any_en   = |en_mask;
  assign drain    = hv_q & out_ready[hold_sel_q];
  assign in_ready = (state_q == RUN) & en_mask[ptr_q]
                  & (~hv_q | out_ready[hold_sel_q]);
  assign acc      = in_valid & in_ready;
  assign last     = (cnt_q == CW'(BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      hv_q       <= 1'b0;
      hold_sel_q <= '0;
    end else begin
      if (acc) begin
        data_q     <= in_data;
        hv_q       <= 1'b1;
        hold_sel_q <= ptr_q;
      end else if (drain) begin
        hv_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (any_en) begin
            ptr_q   <= first_en;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!any_en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (acc) begin
            if (last) begin
              cnt_q <= '0;
              ptr_q <= next_en;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (!en_mask[ptr_q]) begin
            ptr_q <= next_en;
            cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    if (hv_q) begin
      out_data[hold_sel_q*DW +: DW] = data_q;
      out_valid[hold_sel_q]         = 1'b1;
    end
  end

  assign sel  = ptr_q;
  assign busy = hv_q | (cnt_q != '0);

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher (N_OUT=4, DW=8, BURST=4).
// Scenario tasks run in order from one initial block.
module tb_demux_rr_dispatcher;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  en_mask;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [1:0]    sel;
  logic          busy;

  int vecs = 0;
  int errs = 0;

  demux_rr_dispatcher #(.N_OUT(N), .DW(DW), .BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .en_mask   (en_mask),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat i carries data i; bl[i/4] names the lane its burst must hit.
  task automatic stream(input int n, input int bl[4], input string nm);
    logic [N*DW-1:0] ed;
    logic [N-1:0]    ev;
    int              ln;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        ln = bl[(i - 1) / 4];
        ev = '0;
        ev[ln] = 1'b1;
        ed = '0;
        ed[ln*DW +: DW] = DW'(i - 1);
        vecs++;
        if (out_valid !== ev) begin
          errs++;
          $display("FAIL %s valid beat %0d: got %b want %b",
                   nm, i - 1, out_valid, ev);
        end
        vecs++;
        if (out_data !== ed) begin
          errs++;
          $display("FAIL %s data beat %0d: got %h want %h",
                   nm, i - 1, out_data, ed);
        end
      end
      if (i < n) begin
        in_valid = 1'b1;
        in_data  = DW'(i);
        #1;
        vecs++;
        if (in_ready !== 1'b1) begin
          errs++;
          $display("FAIL %s in_ready beat %0d: got %b want 1",
                   nm, i, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    en_mask   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '0;
    @(negedge clk);
    vecs++;
    if ({out_valid, out_data, sel, in_ready, busy} !== '0) begin
      errs++;
      $display("FAIL reset: got v=%b d=%h s=%0d r=%b b=%b want 0",
               out_valid, out_data, sel, in_ready, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if ({in_ready, busy, sel} !== '0) begin
      errs++;
      $display("FAIL idle_after_reset: r=%b b=%b s=%0d want 0",
               in_ready, busy, sel);
    end
  endtask

  task automatic test_all_lanes();
    en_mask   = 4'b1111;
    out_ready = 4'b1111;
    #1;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL idle_ready: got %b want 0", in_ready);
    end
    stream(16, '{0, 1, 2, 3}, "all_lanes");
  endtask

  task automatic test_sparse_mask();
    en_mask = 4'b1010;
    stream(12, '{1, 3, 1, 0}, "sparse");
  endtask

  task automatic test_backpressure();
    en_mask = 4'b0001;
    @(negedge clk);
    vecs++;
    if (sel !== 2'd0) begin
      errs++;
      $display("FAIL bp_sel: got %0d want 0", sel);
    end
    out_ready = 4'b1110;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_first_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_data = 8'h01;
    repeat (5) begin
      #1;
      vecs++;
      if (in_ready !== 1'b0 || out_valid !== 4'b0001
          || out_data !== 32'h0) begin
        errs++;
        $display("FAIL bp_stall: r=%b v=%b d=%h want 0/0001/0",
                 in_ready, out_valid, out_data);
      end
      @(negedge clk);
    end
    out_ready = 4'b1111;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_resume_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    vecs++;
    if (out_valid !== 4'b0001 || out_data !== 32'h01) begin
      errs++;
      $display("FAIL bp_resume: v=%b d=%h want 0001/01",
               out_valid, out_data);
    end
  endtask

  task automatic test_mask_midburst();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    en_mask   = 4'b1110;
    @(negedge clk);
    vecs++;
    if (sel !== 2'd1 || out_valid !== 4'b0001
        || out_data !== 32'h01 || busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_mask: s=%0d v=%b d=%h b=%b want 1/0001/01/1",
               sel, out_valid, out_data, busy);
    end
    out_ready = 4'b1111;
    stream(5, '{1, 2, 0, 0}, "mid_mask");
  endtask

  task automatic test_idle();
    en_mask   = 4'b0000;
    out_ready = 4'b0000;
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 4'b0100
        || out_data !== 32'h0004_0000) begin
      errs++;
      $display("FAIL idle_hold: r=%b b=%b v=%b d=%h",
               in_ready, busy, out_valid, out_data);
    end
    out_ready = 4'b1111;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || out_valid !== 4'b0000) begin
      errs++;
      $display("FAIL idle_drain: b=%b v=%b want 0/0000", busy, out_valid);
    end
    en_mask = 4'b0100;
    @(negedge clk);
    vecs++;
    if (sel !== 2'd2 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL idle_resume: s=%0d r=%b want 2/1", sel, in_ready);
    end
    stream(2, '{2, 2, 2, 2}, "resume");
  endtask

  task automatic test_async_reset();
    out_ready = 4'b0000;
    #1;
    vecs++;
    if (busy !== 1'b1 || sel !== 2'd2) begin
      errs++;
      $display("FAIL pre_reset: b=%b s=%0d want 1/2", busy, sel);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({out_valid, out_data, sel, in_ready, busy} !== '0) begin
      errs++;
      $display("FAIL async_reset: v=%b d=%h s=%0d r=%b b=%b want 0",
               out_valid, out_data, sel, in_ready, busy);
    end
    @(negedge clk);
    en_mask   = 4'b1111;
    out_ready = 4'b1111;
    rst_n     = 1'b1;
    stream(1, '{0, 0, 0, 0}, "post_reset");
  endtask

  initial begin
    test_reset();
    test_all_lanes();
    test_sparse_mask();
    test_backpressure();
    test_mask_midburst();
    test_idle();
    test_async_reset();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
